// File: rtl/ign_sequencer.sv
// Multi-cylinder ignition scheduler: one cylinder per clock through a shared angle adder,
// coil charge/fire decisions over the crank window (prev, cur], overdwell cut-off and enable gating.
module ign_sequencer #(
  parameter int          NCYL           = 4,
  parameter logic [23:0] MAX_DWELL_CLKS = 24'd200000,
  parameter int          DWELL_W        = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            trigger,
  input  logic [15:0]     eng_phase,
  input  logic [15:0]     quanta_per_revolution,
  input  logic [15:0]     ign_timing,
  input  logic [15:0]     dwell_angle,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_addr,
  input  logic [15:0]     cfg_phase,
  output logic [NCYL-1:0] spk_out,
  output logic [NCYL-1:0] overdwell,
  output logic            busy
);

  localparam int IW = (NCYL > 1) ? $clog2(NCYL) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic [15:0]         phase_tbl [NCYL];
  logic [15:0]         cur_phase, prev_phase, pend_phase, cur_src;
  logic                pending, first;
  logic                load_cur, end_scan, set_pend, clr_pend;
  logic [DWELL_W-1:0]  dwell_cnt [NCYL];
  logic [NCYL-1:0]     spk_nx, ovd_hit;

  logic [17:0]         q18, sum, fire_a, chg_a;
  logic signed [17:0]  chg_raw, chg_adj;
  logic                fire_x, chg_x;

  function automatic logic crossed(input logic [17:0] a, input logic [15:0] p, input logic [15:0] c);
    logic [17:0] p18, c18;
    p18 = {2'b00, p};
    c18 = {2'b00, c};
    if (c > p)      return (p18 < a) && (a <= c18);
    else if (c < p) return (a > p18) || (a <= c18);
    else            return 1'b0;
  endfunction

  assign busy = (state == SCAN);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load_cur = 1'b0;
    cur_src  = eng_phase;
    end_scan = 1'b0;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nx = SCAN;
          idx_nx   = '0;
          load_cur = 1'b1;
        end
      end
      SCAN: begin
        if (idx == IW'(NCYL - 1)) begin
          end_scan = 1'b1;
          clr_pend = 1'b1;
          idx_nx   = '0;
          // A trigger in the final scan cycle is newer than any queued one
          if (trigger) begin
            load_cur = 1'b1;
          end else if (pending) begin
            load_cur = 1'b1;
            cur_src  = pend_phase;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          idx_nx   = idx + IW'(1);
          set_pend = trigger;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    q18     = {2'b00, quanta_per_revolution};
    sum     = {2'b00, ign_timing} + {2'b00, phase_tbl[idx]};
    fire_a  = (sum >= q18) ? (sum - q18) : sum;
    chg_raw = $signed(sum) - $signed({2'b00, dwell_angle});
    chg_adj = chg_raw;
    if (chg_raw < 0)
      chg_adj = chg_raw + $signed(q18);
    else if (chg_raw >= $signed(q18))
      chg_adj = chg_raw - $signed(q18);
    chg_a   = $unsigned(chg_adj);
    fire_x  = crossed(fire_a, prev_phase, cur_phase);
    chg_x   = crossed(chg_a, prev_phase, cur_phase);
  end

  always_comb begin
    spk_nx  = spk_out;
    ovd_hit = '0;
    for (int k = 0; k < NCYL; k++) begin
      ovd_hit[k] = spk_out[k] && (dwell_cnt[k] == DWELL_W'(MAX_DWELL_CLKS - 24'd1));
      if (state == SCAN && !first && idx == IW'(k)) begin
        if (fire_x)     spk_nx[k] = 1'b0;
        else if (chg_x) spk_nx[k] = 1'b1;
      end
      if (ovd_hit[k]) spk_nx[k] = 1'b0;
    end
    if (!en) spk_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cur_phase  <= '0;
      prev_phase <= '0;
      pend_phase <= '0;
      pending    <= 1'b0;
      first      <= 1'b1;
      spk_out    <= '0;
      overdwell  <= '0;
      for (int k = 0; k < NCYL; k++) begin
        phase_tbl[k] <= '0;
        dwell_cnt[k] <= '0;
      end
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      spk_out <= spk_nx;
      if (load_cur) cur_phase <= cur_src;
      if (end_scan) begin
        prev_phase <= cur_phase;
        first      <= 1'b0;
      end
      if (clr_pend) begin
        pending <= 1'b0;
      end else if (set_pend) begin
        pending    <= 1'b1;
        pend_phase <= eng_phase;
      end
      for (int k = 0; k < NCYL; k++) begin
        dwell_cnt[k] <= spk_out[k] ? (dwell_cnt[k] + DWELL_W'(1)) : '0;
        if (ovd_hit[k])
          overdwell[k] <= 1'b1;
        else if (cfg_we && cfg_addr == 4'(k))
          overdwell[k] <= 1'b0;
        if (cfg_we && cfg_addr == 4'(k))
          phase_tbl[k] <= cfg_phase;
      end
    end
  end

endmodule
